// File: rtl/addr_83_enc_pkg.sv
// Shared constants, FSM state type and selection helpers for the 8-to-3 event encoder.
package addr_83_enc_pkg;

   localparam int N_LINES = 8;
   localparam int CODE_W  = 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } state_e;

   // Lowest set index wins; returns 0 when nothing is set (caller gates on |req).
   function automatic logic [CODE_W-1:0] sel_lowest(input logic [N_LINES-1:0] req);
      logic [CODE_W-1:0] idx;
      logic              found;
      idx   = '0;
      found = 1'b0;
      for (int j = 0; j < N_LINES; j++) begin
         if (!found && req[j]) begin
            idx   = CODE_W'(j);
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   // First set index found walking upward from start, wrapping 7 -> 0.
   function automatic logic [CODE_W-1:0] sel_from(input logic [N_LINES-1:0] req,
                                                  input logic [CODE_W-1:0]  start);
      logic [CODE_W-1:0] idx;
      logic [CODE_W-1:0] cand;
      logic              found;
      idx   = '0;
      found = 1'b0;
      for (int j = 0; j < N_LINES; j++) begin
         cand = start + CODE_W'(j);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/addr_83_enc_sync.sv
// Input synchroniser for the 8 active-low request lines, plus one cycle of
// history so falling edges (release-to-request transitions) can be detected.
module addr_enc_sync
   import addr_83_enc_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_LINES-1:0] in_n_i,
   output logic [N_LINES-1:0] fall_o,
   output logic               any_low_o
);

   logic [N_LINES-1:0] sync_q [SYNC_STAGES];
   logic [N_LINES-1:0] prev_q;
   logic [N_LINES-1:0] cur;

   assign cur = sync_q[SYNC_STAGES-1];

   // Shift chain and history register; all-high after reset means "nothing requested".
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '1;
         prev_q <= '1;
      end else begin
         sync_q[0] <= in_n_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= cur;
      end
   end

   assign fall_o    = prev_q & ~cur;
   assign any_low_o = |(~cur);

endmodule

// File: rtl/addr_83_enc.sv
// Event encoder: synchronised active-low request lines -> one 3-bit code per
// falling edge, delivered over valid/ready.
// Build option: define ADDR_ENC_RR_EN for round-robin selection; otherwise the
// lowest pending index always wins.
//
// Handshake: addr/valid are registered; a code is consumed at a rising edge
// where valid & ready are both 1. While valid is 1, addr never changes. After
// each accept there is always one cycle with valid low before the next code.
module addr_83_enc
   import addr_83_enc_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_LINES-1:0] in_n,
   input  logic               ready,
   output logic [CODE_W-1:0]  addr,
   output logic               valid,
   output logic               any_low,
   output logic               ovf,
   output state_e             dbg_state
);

   logic [N_LINES-1:0] fall;
   logic [N_LINES-1:0] clr;
   logic [N_LINES-1:0] pending_q, pending_d;
   logic               ovf_q, ovf_d;
   state_e             state_q, state_d;
   logic [CODE_W-1:0]  addr_q, addr_d;
   logic               valid_q, valid_d;
   logic [CODE_W-1:0]  sel;
   logic               accept;

   addr_enc_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .in_n_i    (in_n),
      .fall_o    (fall),
      .any_low_o (any_low)
   );

   assign accept = valid_q & ready;
   assign clr    = accept ? (N_LINES'(1) << addr_q) : '0;

`ifdef ADDR_ENC_RR_EN
   logic [CODE_W-1:0] rr_q, rr_d;

   // Pointer moves one past the code just accepted so every line gets a turn.
   always_comb begin
      rr_d = rr_q;
      if (accept) rr_d = addr_q + CODE_W'(1);
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (rst) rr_q <= '0;
      else     rr_q <= rr_d;
   end

   assign sel = sel_from(pending_q, rr_q);
`else
   assign sel = sel_lowest(pending_q);
`endif

   // Pending events and sticky overflow; a new edge wins over a same-cycle clear.
   always_comb begin
      pending_d = (pending_q & ~clr) | fall;
      ovf_d     = ovf_q | (|(fall & pending_q & ~clr));
   end

   // Output FSM: IDLE picks a pending line, HOLD presents it until accepted.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      valid_d = valid_q;
      case (state_q)
         ST_IDLE: begin
            valid_d = 1'b0;
            if (|pending_q) begin
               addr_d  = sel;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ready) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, output and event registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         valid_q   <= 1'b0;
         pending_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         valid_q   <= valid_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
      end
   end

   assign addr      = addr_q;
   assign valid     = valid_q;
   assign ovf       = ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_addr_83_enc.sv
// Directed bench for addr_83_enc: a cycle-by-cycle vector table for the single
// event case plus hand-written sequences for backpressure, overflow, selection
// order and mid-operation reset.
module tb_addr_83_enc;
   import addr_83_enc_pkg::*;

   typedef struct {
      logic [7:0] in_n;
      logic       ready;
      logic       exp_valid;
      logic [2:0] exp_addr;
      logic       exp_any_low;
      logic       exp_ovf;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       ready;
   logic [7:0] in_n;
   logic [2:0] addr;
   logic       valid;
   logic       any_low;
   logic       ovf;
   state_e     dbg_state;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [2:0] exp_q[$];
   vec_t       vecs[32];

   addr_83_enc #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_n      (in_n),
      .ready     (ready),
      .addr      (addr),
      .valid     (valid),
      .any_low   (any_low),
      .ovf       (ovf),
      .dbg_state (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   // Advance one clock; outputs are then examined 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      in_n  = 8'hFF;
      ready = 1'b0;
      steps(2);
      rst = 1'b0;
   endtask

   // Wait (bounded) for valid, then compare addr with the head of the expected queue.
   task automatic collect(input string nm);
      logic [2:0] e;
      int         k;
      k = 0;
      while (valid !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
      chk({nm, "_valid"}, {7'd0, valid}, 8'd1);
      chk({nm, "_addr"}, {5'd0, addr}, {5'd0, e});
   endtask

   task automatic expect_quiet(input string nm, input int n);
      for (int i = 0; i < n; i++) begin
         step();
         chk(nm, {7'd0, valid}, 8'd0);
      end
   endtask

   initial begin
      // ---- 1: reset and idle ----
      do_reset();
      chk("rst_valid",   {7'd0, valid},   8'd0);
      chk("rst_addr",    {5'd0, addr},    8'd0);
      chk("rst_any_low", {7'd0, any_low}, 8'd0);
      chk("rst_ovf",     {7'd0, ovf},     8'd0);
      chk("rst_state",   {7'd0, dbg_state}, 8'd0);
      expect_quiet("idle_valid", 20);

      // ---- 2: single event, table of per-cycle expectations ----
      vecs[0] = '{8'hFB, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0};
      vecs[1] = '{8'hFB, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[2] = '{8'hFB, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0};
      vecs[3] = '{8'hFB, 1'b1, 1'b1, 3'd2, 1'b1, 1'b0};
      vecs[4] = '{8'hFB, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
      for (int i = 5; i < 30; i++) vecs[i] = '{8'hFB, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
      vecs[30] = '{8'hFF, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0};
      vecs[31] = '{8'hFF, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0};
      for (int i = 0; i < 32; i++) begin
         in_n  = vecs[i].in_n;
         ready = vecs[i].ready;
         step();
         chk($sformatf("single_valid[%0d]", i),   {7'd0, valid},   {7'd0, vecs[i].exp_valid});
         chk($sformatf("single_addr[%0d]", i),    {5'd0, addr},    {5'd0, vecs[i].exp_addr});
         chk($sformatf("single_any_low[%0d]", i), {7'd0, any_low}, {7'd0, vecs[i].exp_any_low});
         chk($sformatf("single_ovf[%0d]", i),     {7'd0, ovf},     {7'd0, vecs[i].exp_ovf});
      end

      // ---- 3: simultaneous lines 0 and 7 with backpressure ----
      do_reset();
      in_n = 8'h7E;
      exp_q.push_back(3'd0);
      collect("simul_first");
      for (int i = 0; i < 10; i++) begin
         step();
         chk("simul_hold_valid", {7'd0, valid}, 8'd1);
         chk("simul_hold_addr",  {5'd0, addr},  8'd0);
      end
      ready = 1'b1;
      step();
      chk("simul_gap_valid", {7'd0, valid}, 8'd0);
      step();
      chk("simul_second_valid", {7'd0, valid}, 8'd1);
      chk("simul_second_addr",  {5'd0, addr},  8'd7);
      expect_quiet("simul_done_valid", 10);

      // ---- 4: overflow on a line that is still pending ----
      do_reset();
      in_n = 8'hDF;
      exp_q.push_back(3'd5);
      collect("ovf_first");
      in_n = 8'hFF;
      steps(3);
      chk("ovf_before", {7'd0, ovf}, 8'd0);
      in_n = 8'hDF;
      steps(3);
      chk("ovf_set",        {7'd0, ovf},   8'd1);
      chk("ovf_hold_valid", {7'd0, valid}, 8'd1);
      chk("ovf_hold_addr",  {5'd0, addr},  8'd5);
      steps(5);
      chk("ovf_sticky", {7'd0, ovf}, 8'd1);
      ready = 1'b1;
      expect_quiet("ovf_single_code", 10);
      chk("ovf_sticky_end", {7'd0, ovf}, 8'd1);

      // ---- 5: selection order after a late edge on line 0 ----
      do_reset();
      in_n = 8'hF9;
      exp_q.push_back(3'd1);
      collect("sel_first");
      in_n = 8'hF8;
      steps(3);
      ready = 1'b1;
      step();
      chk("sel_gap_valid", {7'd0, valid}, 8'd0);
`ifdef ADDR_ENC_RR_EN
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd0);
`else
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd2);
`endif
      collect("sel_second");
      step();
      collect("sel_third");
      expect_quiet("sel_done_valid", 10);

      // ---- 6: reset while a code is held ----
      do_reset();
      in_n = 8'hAF;
      exp_q.push_back(3'd4);
      collect("midrst_first");
      rst  = 1'b1;
      in_n = 8'hFF;
      ready = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_valid", {7'd0, valid}, 8'd0);
      chk("midrst_addr",  {5'd0, addr},  8'd0);
      chk("midrst_ovf",   {7'd0, ovf},   8'd0);
      expect_quiet("midrst_quiet", 15);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
